frame_loader: RTL

Upstream feeder for the Viterbi decoder's symbol slicer. Accepts 16-bit received-data words from the PS-side stream over a valid/ready handshake and buffers them in a small FIFO. Presents one frame at a time on `o_data_frame` and holds it while pulsing `o_en_s` for exactly the number of slicer beats that frame needs. Flags end of data on `o_ood` once the last frame is fully consumed.

---
 rtl/frame_loader.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/frame_loader.sv
// Frame loader: buffers PS words in a small FIFO and presents one frame at a time to the
// Viterbi symbol slicer. Optional underrun counter is enabled by FRAME_LOADER_UNDERRUN_CNT_EN.
module frame_loader #(
  parameter int DEPTH   = 4,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_code_rate,
  input  logic               i_start,
  input  logic               i_wr_valid,
  input  logic [FRAME_W-1:0] i_wr_data,
  input  logic               i_wr_last,
  output logic               o_wr_ready,
  output logic [FRAME_W-1:0] o_data_frame,
  output logic               o_en_s,
  output logic               o_ood,
  output logic               o_busy
`ifdef FRAME_LOADER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]        o_underrun_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               rate_q, rate_d;
  logic [1:0]         beat_q, beat_d;
  logic               last_q, last_d;
  logic               last_seen_q, last_seen_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               en_q, en_d;
  logic               ood_q, ood_d;
  logic               busy_q, busy_d;
  logic               wr_ready_q, wr_ready_d;

  logic [FRAME_W-1:0] mem_q      [DEPTH];
  logic               mem_last_q [DEPTH];

  logic               empty;
  logic               full_d;
  logic               push;
  logic               pop;
  logic               start_run;
  logic               start_done;
  logic [1:0]         beats_m1;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign push       = i_wr_valid && wr_ready_q;
  assign start_run  = (state_q == S_IDLE) && i_start;
  assign start_done = (state_q == S_DONE) && i_start;
  assign beats_m1   = (rate_q == CODE_RATE_3) ? 2'd1 : 2'd3;

  // Pop either on the first fetch or directly at the last beat, so back-to-back frames have no bubble.
  assign pop = ((state_q == S_FETCH) && !empty) ||
               ((state_q == S_EMIT) && (beat_q == 2'd0) && !last_q && !empty);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (!empty) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (beat_q == 2'd0) begin
          if (last_q)      state_d = S_DONE;
          else if (empty)  state_d = S_FETCH;
          else             state_d = S_EMIT;
        end
      end
      S_DONE: begin
        if (i_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and FIFO pointer next values
  always_comb begin
    rate_d      = rate_q;
    beat_d      = beat_q;
    last_d      = last_q;
    last_seen_d = last_seen_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_d     = frame_q;

    if (start_run) begin
      rate_d      = i_code_rate;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      last_seen_d = 1'b0;
    end else begin
      wr_ptr_d    = wr_ptr_q + PW'(push);
      rd_ptr_d    = rd_ptr_q + PW'(pop);
      last_seen_d = last_seen_q | (push & i_wr_last);
    end

    if (pop) begin
      frame_d = mem_q[rd_ptr_q[AW-1:0]];
      last_d  = mem_last_q[rd_ptr_q[AW-1:0]];
      beat_d  = beats_m1;
    end else if ((state_q == S_EMIT) && (beat_q != 2'd0)) begin
      beat_d  = beat_q - 2'd1;
    end

    if (start_done) begin
      frame_d = '0;
    end
  end

  // Output logic: next values of the registered outputs, decoded from the next state
  always_comb begin
    full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    en_d       = (state_d == S_EMIT);
    ood_d      = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
    wr_ready_d = !full_d && !last_seen_d && ((state_d == S_FETCH) || (state_d == S_EMIT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rate_q      <= CODE_RATE_2;
      beat_q      <= 2'd0;
      last_q      <= 1'b0;
      last_seen_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_q     <= '0;
      en_q        <= 1'b0;
      ood_q       <= 1'b0;
      busy_q      <= 1'b0;
      wr_ready_q  <= 1'b0;
    end else begin
      rate_q      <= rate_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      last_seen_q <= last_seen_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_q     <= frame_d;
      en_q        <= en_d;
      ood_q       <= ood_d;
      busy_q      <= busy_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  // FIFO storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]]      <= i_wr_data;
      mem_last_q[wr_ptr_q[AW-1:0]] <= i_wr_last;
    end
  end

  assign o_wr_ready   = wr_ready_q;
  assign o_data_frame = frame_q;
  assign o_en_s       = en_q;
  assign o_ood        = ood_q;
  assign o_busy       = busy_q;

`ifdef FRAME_LOADER_UNDERRUN_CNT_EN
  logic        first_q, first_d;
  logic [15:0] ucnt_q, ucnt_d;

  // Only gaps after the first frame of the run count as underruns.
  always_comb begin
    first_d = first_q;
    ucnt_d  = ucnt_q;
    if (start_run || start_done) begin
      first_d = 1'b0;
      ucnt_d  = '0;
    end else begin
      if (pop) first_d = 1'b1;
      if ((state_q == S_FETCH) && empty && first_q && (ucnt_q != 16'hFFFF)) begin
        ucnt_d = ucnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      first_q <= first_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign o_underrun_cnt = ucnt_q;
`endif

endmodule
